fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter placed directly downstream of the 8-entry byte FIFO. It pops bytes through the FIFO read port (`out`/`re`/`empty`) and shifts each byte out on a single line as 8N1 UART frames: one start bit, eight data bits LSB first, one stop bit. While the FIFO stays non-empty it sends frames back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `tx_en`  input  1  when 1, the block may start new frames; when 0, no new pop, but a frame in flight completes.
- `fifo_data`  input  8  FIFO head byte (FIFO `out`); combinational from the FIFO, valid whenever `fifo_empty`=0.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_re`  output  1  pop strobe to FIFO `re`; one cycle per byte consumed.
- `txd`  output  1  serial line; idles at 1.
- `busy`  output  1  1 while a frame is in progress (state != IDLE).
- `done`  output  1  1 during the final cycle of each stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Internal registers: 8-bit shift register `sh`, baud counter `bc` (width clog2(CLKS_PER_BIT)), 3-bit bit index `bi`.
- `pop` = `rst` & `tx_en` & !`fifo_empty` & (state==IDLE | (state==STOP & `bc`==CLKS_PER_BIT-1)).
- `fifo_re` = `pop`. It is combinational and forced to 0 while `rst`=0.
- The block never asserts `fifo_re` while `fifo_empty`=1. The FIFO advances its tail unconditionally on `re`, so this rule must hold in every state.
- On a pop edge:
  - `sh` <= `fifo_data`; `bc` <= 0; `bi` <= 0; state <= START.
  - The FIFO advances its tail on the same edge.
- START: `txd`=0. When `bc`==CLKS_PER_BIT-1: `bc` <= 0, state <= DATA. Otherwise `bc`++.
- DATA: `txd`=`sh[0]`.
  - At `bc`==CLKS_PER_BIT-1: `sh` <= `sh`>>1, `bc` <= 0.
  - If `bi`==7, state <= STOP; otherwise `bi`++.
- STOP: `txd`=1.
  - At `bc`==CLKS_PER_BIT-1: if `pop`, reload as above (next state START); else state <= IDLE.
  - Otherwise `bc`++.
- IDLE: `txd`=1. Pop when the `pop` condition holds.
- `txd` is registered: it is driven from the state and `sh`, with no combinational path from the inputs.
- `done` = (state==STOP & `bc`==CLKS_PER_BIT-1).

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `bc`=0, `bi`=0, `sh`=0, `txd`=1, `busy`=0, `done`=0, `fifo_re`=0.
- Reset asserted mid-frame aborts the frame immediately. `txd` returns to 1 without waiting for a clock, and the popped byte is lost.
- After `rst` deasserts, the first pop occurs on the first rising edge with `tx_en`=1 and `fifo_empty`=0.
- Pop-to-start latency: `txd` falls on the cycle after the `fifo_re` edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
- Back-to-back frames: the next start bit follows the stop bit's final cycle with zero idle cycles. Frame period is 10*CLKS_PER_BIT.
- `tx_en` is sampled only at pop opportunities. Dropping it mid-frame has no effect until the current stop bit ends; the block then goes to IDLE.
- FIFO write and the block's pop in the same cycle are legal; the FIFO handles simultaneous `we`/`re`.
- A byte written into an empty FIFO is popped on the edge after the write: `fifo_empty` falls combinationally after that write edge.

## Test plan
- Reset values: CLKS_PER_BIT=4, hold `rst`=0 with `fifo_empty`=0 and `tx_en`=1 -> `txd`=1, `busy`=0, `fifo_re`=0 throughout.
- Single byte: CLKS_PER_BIT=4, one write of 0xA5 into the FIFO.
  - Expect exactly one `fifo_re` pulse.
  - `txd` runs 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - `done` pulses once on cycle 40; `busy` then drops to 0.
- Back-to-back: write 0x00, 0xFF, 0x3C.
  - Expect three `fifo_re` pulses spaced exactly 40 cycles apart.
  - No idle-high cycle between the stop bit and the next start bit.
  - Decoded bytes are 0x00, 0xFF, 0x3C; the FIFO ends empty.
- Empty guard: FIFO empty for 200 cycles with `tx_en`=1 -> `fifo_re` never asserts, `txd`=1, `busy`=0.
- Enable gating: 3 bytes queued, drop `tx_en` 10 cycles into the first frame.
  - The first frame completes; `fifo_re` does not pulse again and the FIFO still holds 2 bytes.
  - On re-raising `tx_en`, the next pop occurs on the first edge.
- Mid-frame reset: pull `rst` low during data bit 3 -> `txd`=1 and `busy`=0 asynchronously. After release with a non-empty FIFO, a clean new frame starts with the next byte.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// 8N1 serial transmitter that pops bytes from the head of an 8-entry byte FIFO.
// It shifts each byte out as one start bit, eight data bits LSB first and one
// stop bit. While the FIFO stays non-empty and transmission is enabled, frames
// run back-to-back: a new byte is popped on the final cycle of the stop bit.
// The serial line is registered, so txd has no combinational path from the
// inputs, and it is forced high asynchronously by reset.

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_re,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    // Baud counter width; at least one bit so the smallest legal rate still works.
    localparam int BC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_rate
            $error("fifo_uart_tx: CLKS_PER_BIT must lie in 2..65535");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [7:0]      r_sh;
    logic [BC_W-1:0] r_bc;
    logic [2:0]      r_bi;
    logic            r_txd;

    logic [1:0]      w_state_nxt;
    logic [7:0]      w_sh_nxt;
    logic [BC_W-1:0] w_bc_nxt;
    logic [2:0]      w_bi_nxt;
    logic            w_txd_nxt;
    logic            w_bit_end;
    logic            w_pop;

    // Last cycle of the current serial bit.
    assign w_bit_end = (r_bc == BC_LAST);

    // A pop is only ever taken when the FIFO holds data: the FIFO advances its
    // tail on every re pulse, so an unguarded pop would corrupt it. Holding
    // reset low also suppresses the pop, keeping fifo_re quiet during reset.
    assign w_pop = rst & tx_en & ~fifo_empty &
                   ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

    assign fifo_re = w_pop;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_STOP) & w_bit_end;
    assign txd     = r_txd;

    // Next-state logic: a pop reloads the frame from the FIFO head, otherwise
    // the baud counter paces the walk through START, DATA and STOP.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_bc_nxt    = r_bc;
        w_bi_nxt    = r_bi;
        if (w_pop) begin
            w_sh_nxt    = fifo_data;
            w_bc_nxt    = '0;
            w_bi_nxt    = 3'd0;
            w_state_nxt = S_START;
        end else begin
            case (r_state)
                S_START: begin
                    if (w_bit_end) begin
                        w_bc_nxt    = '0;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_bc_nxt = r_bc + BC_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        w_sh_nxt = {1'b0, r_sh[7:1]};
                        w_bc_nxt = '0;
                        if (r_bi == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bi_nxt = r_bi + 3'd1;
                        end
                    end else begin
                        w_bc_nxt = r_bc + BC_ONE;
                    end
                end
                S_STOP: begin
                    // The stop bit ending with a pop was handled above.
                    if (w_bit_end) begin
                        w_bc_nxt    = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bc_nxt = r_bc + BC_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Line level for the coming cycle, derived from the next state and shift
    // register so txd changes in step with the state it belongs to.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_sh_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame in flight and idles the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sh    <= 8'd0;
            r_bc    <= '0;
            r_bi    <= 3'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_bc    <= w_bc_nxt;
            r_bi    <= w_bi_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small FIFO model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_re;
    logic       txd;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    // FIFO model (8 entries), write port driven from the stimulus
    logic       we = 1'b0;
    logic [7:0] wd = 8'd0;
    logic [7:0] mem [8];
    logic [2:0] wp = 3'd0;
    logic [2:0] rp = 3'd0;
    int         fcnt = 0;
    int         re_pulses = 0;
    int         underflow = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    assign fifo_empty = (fcnt == 0);
    assign fifo_data  = mem[rp];

    always @(posedge clk) begin
        if (we) begin
            mem[wp] <= wd;
            wp      <= wp + 3'd1;
        end
        if (fifo_re) begin
            rp        <= rp + 3'd1;
            re_pulses <= re_pulses + 1;
            if (fcnt == 0) underflow <= underflow + 1;
        end
        fcnt <= fcnt + (we ? 1 : 0) - (fifo_re ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write one byte; called at a falling edge, returns at the next one.
    task automatic push(input logic [7:0] b);
        we = 1'b1;
        wd = b;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Called in the cycle whose rising edge pops byte b. Captures the 40-cycle
    // frame and checks every bit, done, busy and that no pop happens mid-frame.
    task automatic run_frame(input logic [7:0] b, input logic nxt, input int drop_at);
        logic [40:1] s;
        logic [7:0]  dec;
        logic [3:0]  grp;
        logic        e;
        int          dn;
        int          rc;
        int          bb;
        dn = 0; rc = 0; bb = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            s[c] = txd;
            if (done) dn++;
            if (!busy) bb++;
            if (c < 40 && fifo_re) rc++;
            if (c == 40) begin
                chk($sformatf("%02h_done_last", b), 32'(done), 32'(1'b1));
                chk($sformatf("%02h_re_at_stop_end", b), 32'(fifo_re), 32'(nxt));
            end
            if (c == drop_at) tx_en = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            e   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            grp = s[4*k+1 +: 4];
            chk($sformatf("%02h_bit%0d", b, k), 32'(grp), 32'({4{e}}));
        end
        for (int k = 0; k < 8; k++) dec[k] = s[4*(k+1)+2];
        chk($sformatf("%02h_decoded", b), 32'(dec), 32'(b));
        chk($sformatf("%02h_done_count", b), dn, 1);
        chk($sformatf("%02h_re_mid_frame", b), rc, 0);
        chk($sformatf("%02h_busy_low_in_frame", b), bb, 0);
    endtask

    initial begin
        int r0;
        int bad_txd;
        int bad_busy;
        int bad_re;

        // Reset hold with data available
        rst   = 1'b0;
        tx_en = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h5A);
        bad_txd = 0; bad_busy = 0; bad_re = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_re !== 1'b0) bad_re++;
        end
        chk("rst_txd_high", bad_txd, 0);
        chk("rst_busy_low", bad_busy, 0);
        chk("rst_re_low", bad_re, 0);
        chk("rst_done_low", 32'(done), 32'(1'b0));
        chk("rst_fifo_kept", fcnt, 1);
        rst = 1'b1;
        #1;
        chk("first_pop_after_release", 32'(fifo_re), 32'(1'b1));
        run_frame(8'h5A, 1'b0, 0);
        @(negedge clk);
        chk("5a_idle_busy", 32'(busy), 32'(1'b0));

        // Single byte 0xA5
        r0 = re_pulses;
        push(8'hA5);
        chk("a5_pop_after_write", 32'(fifo_re), 32'(1'b1));
        run_frame(8'hA5, 1'b0, 0);
        @(negedge clk);
        chk("a5_busy_after", 32'(busy), 32'(1'b0));
        chk("a5_txd_after", 32'(txd), 32'(1'b1));
        chk("a5_re_pulses", re_pulses - r0, 1);

        // Back-to-back frames
        tx_en = 1'b0;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        r0 = re_pulses;
        tx_en = 1'b1;
        #1;
        chk("b2b_first_pop", 32'(fifo_re), 32'(1'b1));
        run_frame(8'h00, 1'b1, 0);
        run_frame(8'hFF, 1'b1, 0);
        run_frame(8'h3C, 1'b0, 0);
        @(negedge clk);
        chk("b2b_re_pulses", re_pulses - r0, 3);
        chk("b2b_fifo_empty", fcnt, 0);
        chk("b2b_busy_after", 32'(busy), 32'(1'b0));

        // Empty FIFO guard
        bad_txd = 0; bad_busy = 0; bad_re = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_re !== 1'b0) bad_re++;
        end
        chk("empty_txd_high", bad_txd, 0);
        chk("empty_busy_low", bad_busy, 0);
        chk("empty_no_re", bad_re, 0);

        // Enable gating
        tx_en = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        r0 = re_pulses;
        tx_en = 1'b1;
        #1;
        chk("en_first_pop", 32'(fifo_re), 32'(1'b1));
        run_frame(8'h11, 1'b0, 10);
        bad_re = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_re !== 1'b0) bad_re++;
        end
        chk("en_no_re_while_off", bad_re, 0);
        chk("en_re_pulses", re_pulses - r0, 1);
        chk("en_fifo_holds_two", fcnt, 2);
        chk("en_busy_idle", 32'(busy), 32'(1'b0));
        tx_en = 1'b1;
        #1;
        chk("en_pop_on_reenable", 32'(fifo_re), 32'(1'b1));
        run_frame(8'h22, 1'b1, 0);
        run_frame(8'h33, 1'b0, 0);

        // Mid-frame reset during data bit 3 of 0x44
        tx_en = 1'b0;
        push(8'h44);
        push(8'h55);
        tx_en = 1'b1;
        #1;
        chk("mr_first_pop", 32'(fifo_re), 32'(1'b1));
        repeat (18) @(negedge clk);
        chk("mr_bit3_low", 32'(txd), 32'(1'b0));
        chk("mr_busy_before", 32'(busy), 32'(1'b1));
        rst = 1'b0;
        #1;
        chk("mr_txd_async", 32'(txd), 32'(1'b1));
        chk("mr_busy_async", 32'(busy), 32'(1'b0));
        chk("mr_re_in_reset", 32'(fifo_re), 32'(1'b0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_fifo_one_left", fcnt, 1);
        chk("mr_pop_after_release", 32'(fifo_re), 32'(1'b1));
        run_frame(8'h55, 1'b0, 0);
        @(negedge clk);
        chk("mr_fifo_empty", fcnt, 0);
        chk("mr_busy_after", 32'(busy), 32'(1'b0));

        chk("no_underflow", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
